// File: rtl/rx_bram_pkg.sv
// Shared constants and state type for the RX sample-BRAM capture controller.
package rx_bram_pkg;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 18;
  localparam int DEPTH  = 1 << ADDR_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_POST  = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;
endpackage

// File: rtl/rx_bram_capture_ctrl_if.sv
// Drain stream towards the correlator plus both rx_BRAM ports.
// master = capture controller side, slave = consumer / BRAM side.
interface rx_bram_capture_ctrl_if #(
  parameter int ADDR_W = rx_bram_pkg::ADDR_W,
  parameter int DATA_W = rx_bram_pkg::DATA_W
);
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;
  logic              m_last;
  logic              bram_ena;
  logic              bram_wea;
  logic [ADDR_W-1:0] bram_addra;
  logic [DATA_W-1:0] bram_dia;
  logic              bram_enb;
  logic [ADDR_W-1:0] bram_addrb;
  logic [DATA_W-1:0] bram_dob;

  modport master (
    output m_data, m_valid, m_last,
    input  m_ready,
    output bram_ena, bram_wea, bram_addra, bram_dia,
    output bram_enb, bram_addrb,
    input  bram_dob
  );

  modport slave (
    input  m_data, m_valid, m_last,
    output m_ready,
    input  bram_ena, bram_wea, bram_addra, bram_dia,
    input  bram_enb, bram_addrb,
    output bram_dob
  );
endinterface

// File: rtl/rx_skid_buf.sv
// Output register plus one skid entry. Output is held stable while stalled;
// the skid entry absorbs the read that was already in flight when the stall hit.
// count = entries held, used upstream to decide whether another read may issue.
module rx_skid_buf #(
  parameter int W = 19
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic [1:0]   count
);
  logic         sk_vld;
  logic [W-1:0] sk_dat;
  logic         load_out;

  // out stage may take new data when empty or when being popped
  assign load_out = !out_valid || out_ready;
  assign count    = {1'b0, out_valid} + {1'b0, sk_vld};

  // out register refills from skid first (oldest), else from input
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      sk_vld    <= 1'b0;
      sk_dat    <= '0;
    end else if (load_out) begin
      if (sk_vld) begin
        out_valid <= 1'b1;
        out_data  <= sk_dat;
        sk_vld    <= in_valid;
        sk_dat    <= in_data;
      end else begin
        out_valid <= in_valid;
        if (in_valid) out_data <= in_data;
      end
    end else if (in_valid) begin
      sk_vld <= 1'b1;
      sk_dat <= in_data;
    end
  end
endmodule

// File: rtl/rx_bram_capture_ctrl.sv
// Triggered ring-buffer capture into the RX sample BRAM, then oldest-first drain.
// Port A writes the live stream while armed/post-trigger; port B reads during drain
// through a 1-cycle-latency path into rx_skid_buf.
module rx_bram_capture_ctrl #(
  parameter int ADDR_W    = rx_bram_pkg::ADDR_W,
  parameter int DATA_W    = rx_bram_pkg::DATA_W,
  parameter int POST_TRIG = 768
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   arm,
  input  logic                   abort,
  input  logic [DATA_W-1:0]      s_data,
  input  logic                   s_valid,
  input  logic                   trigger,
  output logic                   busy,
  output logic                   done,
  output logic                   ovf,
  rx_bram_capture_ctrl_if.master bus
);
  localparam int            CW      = ADDR_W + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(1 << ADDR_W);
  localparam logic [CW-1:0] POST_C  = CW'(POST_TRIG);
  // fill needed so the finished capture holds a full buffer of real samples
  localparam logic [CW-1:0] PRIME_C = DEPTH_C - POST_C;

  import rx_bram_pkg::*;

  state_e            state;
  logic [ADDR_W-1:0] wr_ptr;
  logic [CW-1:0]     fill, post_cnt, rd_cnt;
  logic              rd_pend, rd_pend_last;
  logic              wr_en, rd_issue, primed, trig_hit, pop, hs_last;
  logic [1:0]        skid_cnt, occ_nxt;
  logic              sk_vld;
  logic [DATA_W:0]   sk_word;

  assign wr_en    = rst_n && s_valid && (state == ST_ARMED || state == ST_POST);
  assign primed   = fill >= PRIME_C;
  assign trig_hit = (state == ST_ARMED) && s_valid && trigger && primed;

  // a new read may issue if the skid stage can still hold it once the
  // read already in flight lands (accounting for this cycle's pop)
  assign pop      = sk_vld && bus.m_ready;
  assign occ_nxt  = skid_cnt + {1'b0, rd_pend} - {1'b0, pop};
  assign rd_issue = rst_n && !abort && (state == ST_DRAIN) &&
                    (rd_cnt < DEPTH_C) && (occ_nxt <= 2'd1);

  assign hs_last  = pop && sk_word[DATA_W];
  assign done     = rst_n && !abort && (state == ST_DRAIN) && hs_last;
  assign busy     = (state != ST_IDLE);

  assign bus.bram_ena   = wr_en;
  assign bus.bram_wea   = wr_en;
  assign bus.bram_addra = wr_en ? wr_ptr : '0;
  assign bus.bram_dia   = wr_en ? s_data : '0;
  assign bus.bram_enb   = rd_issue;
  assign bus.bram_addrb = rd_issue ? wr_ptr + rd_cnt[ADDR_W-1:0] : '0;

  assign bus.m_valid = sk_vld;
  assign bus.m_data  = sk_word[DATA_W-1:0];
  assign bus.m_last  = sk_vld && sk_word[DATA_W];

  // FSM, write pointer, fill/post/read counters and sticky overflow
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      wr_ptr   <= '0;
      fill     <= '0;
      post_cnt <= '0;
      rd_cnt   <= '0;
      ovf      <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (fill != DEPTH_C) fill <= fill + 1'b1;
      end
      if (rd_issue) rd_cnt <= rd_cnt + 1'b1;
      if (state == ST_DRAIN && s_valid) ovf <= 1'b1;

      if (abort) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: if (arm) begin
            state    <= ST_ARMED;
            fill     <= '0;
            post_cnt <= '0;
            ovf      <= 1'b0;
          end
          ST_ARMED: if (trig_hit) begin
            post_cnt <= CW'(1);
            rd_cnt   <= '0;
            state    <= (POST_TRIG == 1) ? ST_DRAIN : ST_POST;
          end
          ST_POST: if (s_valid) begin
            post_cnt <= post_cnt + 1'b1;
            if (post_cnt + 1'b1 == POST_C) begin
              state  <= ST_DRAIN;
              rd_cnt <= '0;
            end
          end
          ST_DRAIN: if (hs_last) state <= ST_IDLE;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  // tracks the read whose data appears on bram_dob this cycle
  always_ff @(posedge clk) begin
    if (!rst_n || abort) begin
      rd_pend      <= 1'b0;
      rd_pend_last <= 1'b0;
    end else begin
      rd_pend      <= rd_issue;
      rd_pend_last <= rd_issue && (rd_cnt == DEPTH_C - 1'b1);
    end
  end

  rx_skid_buf #(.W(DATA_W + 1)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (abort),
    .in_valid  (rd_pend),
    .in_data   ({rd_pend_last, bus.bram_dob}),
    .out_ready (bus.m_ready),
    .out_valid (sk_vld),
    .out_data  (sk_word),
    .count     (skid_cnt)
  );
endmodule

// File: tb/tb_rx_bram_capture_ctrl.sv
// Randomized bench for rx_bram_capture_ctrl with a behavioural ring-buffer model.
module tb_rx_bram_capture_ctrl;
  localparam int ADDR_W = 10, DATA_W = 18, POST_TRIG = 768, DEPTH = 1 << ADDR_W;
  localparam int M_IDLE = 0, M_ARMED = 1, M_POST = 2, M_DRAIN = 3;

  logic clk = 0, rst_n = 0, arm = 0, abort = 0, s_valid = 0, trigger = 0;
  logic busy, done, ovf;
  logic [DATA_W-1:0] s_data = '0;

  rx_bram_capture_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  rx_bram_capture_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .POST_TRIG(POST_TRIG)) dut (
    .clk(clk), .rst_n(rst_n), .arm(arm), .abort(abort), .s_data(s_data),
    .s_valid(s_valid), .trigger(trigger), .busy(busy), .done(done), .ovf(ovf), .bus(bus)
  );

  always #5 clk = ~clk;

  // simple dual-port BRAM, read latency 1
  logic [DATA_W-1:0] bram [DEPTH];
  always @(posedge clk) begin
    if (bus.bram_ena && bus.bram_wea) bram[bus.bram_addra] <= bus.bram_dia;
    if (bus.bram_enb) bus.bram_dob <= bram[bus.bram_addrb];
  end

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_mode = M_IDLE, m_wptr = 0, m_fill = 0, m_post = 0, dcyc = 0, beats = 0;
  int done_cnt = 0, first_beat = -1, last_beat = -1, fill_before;
  logic m_ovf = 0, stall_prev = 0, hs, cap, exp_done;
  logic [DATA_W+1:0] prev_word;
  logic [DATA_W-1:0] mmem [DEPTH];
  logic [DATA_W-1:0] exp_q [$];

  task automatic enter_drain();
    m_mode = M_DRAIN;
    dcyc = 0;
    beats = 0;
    exp_q.delete();
    for (int i = 0; i < DEPTH; i++) exp_q.push_back(mmem[(m_wptr + i) % DEPTH]);
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      m_mode = M_IDLE; m_wptr = 0; m_fill = 0; m_post = 0; m_ovf = 0;
      stall_prev = 0; exp_q.delete();
    end else begin
      cap = (m_mode == M_ARMED || m_mode == M_POST);
      chk("busy", busy, m_mode != M_IDLE);
      chk("ovf", ovf, m_ovf);
      chk("wr_en", {bus.bram_ena, bus.bram_wea}, {2{cap && s_valid}});
      if (cap && s_valid) begin
        chk("addra", bus.bram_addra, m_wptr);
        chk("dia", bus.bram_dia, s_data);
      end
      if (m_mode != M_DRAIN) chk("enb_outside_drain", bus.bram_enb, 0);
      chk("valid_window", bus.m_valid && !(m_mode == M_DRAIN && dcyc >= 2), 0);
      if (stall_prev) chk("hold", {bus.m_valid, bus.m_last, bus.m_data}, prev_word);

      hs = bus.m_valid && bus.m_ready && m_mode == M_DRAIN;
      exp_done = 0;
      if (hs) begin
        chk("q_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) chk("data", bus.m_data, exp_q.pop_front());
        chk("last", bus.m_last, beats == DEPTH - 1);
        if (beats == 0) first_beat = int'(bus.m_data);
        last_beat = int'(bus.m_data);
        beats++;
        exp_done = (beats == DEPTH) && !abort;
      end
      chk("done", done, exp_done);
      if (done) done_cnt++;
      stall_prev = bus.m_valid && !bus.m_ready && !abort;
      prev_word  = {bus.m_valid, bus.m_last, bus.m_data};

      // advance model to next cycle
      fill_before = m_fill;
      if (cap && s_valid) begin
        mmem[m_wptr] = s_data;
        m_wptr = (m_wptr + 1) % DEPTH;
        if (m_fill < DEPTH) m_fill++;
      end
      if (m_mode == M_DRAIN && s_valid) m_ovf = 1;
      if (m_mode == M_DRAIN) dcyc++;
      if (abort) begin
        m_mode = M_IDLE;
        exp_q.delete();
      end else begin
        case (m_mode)
          M_IDLE: if (arm) begin m_mode = M_ARMED; m_fill = 0; m_post = 0; m_ovf = 0; end
          M_ARMED: if (trigger && s_valid && fill_before >= DEPTH - POST_TRIG) begin
            m_post = 1;
            if (m_post == POST_TRIG) enter_drain(); else m_mode = M_POST;
          end
          M_POST: if (s_valid) begin
            m_post++;
            if (m_post == POST_TRIG) enter_drain();
          end
          default: if (exp_done) m_mode = M_IDLE;
        endcase
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    s_valid = 0; trigger = 0; abort = 0; arm = 0; bus.m_ready = 0;
    tick(); tick();
  endtask

  task automatic chk_zero(input string name);
    chk(name, {bus.m_valid, bus.m_last, done, busy, ovf, bus.bram_ena, bus.bram_wea,
               bus.bram_enb, bus.bram_addra, bus.bram_addrb, bus.bram_dia, bus.m_data}, 64'd0);
  endtask

  task automatic run_capture(input int trig_a, input int trig_b, input int vpct,
                             input int vpct_dr, input int rpct, input int abort_at,
                             input int rst_at);
    int smp, cyc;
    logic v;
    smp = 0; cyc = 0;
    first_beat = -1; last_beat = -1;
    arm = 1; tick(); arm = 0;
    chk("arm_clears_ovf", ovf, 0);
    chk("arm_busy", busy, 1);
    while (1) begin
      if (rst_at >= 0 && smp == rst_at) begin
        rst_n = 0; s_valid = 0; trigger = 0;
        tick();
        chk_zero("reset_mid_post");
        rst_n = 1;
        idle_inputs();
        return;
      end
      v = ($urandom_range(99) < ((m_mode == M_DRAIN) ? vpct_dr : vpct));
      s_valid = v;
      s_data  = DATA_W'(smp);
      trigger = v ? (smp == trig_a || smp == trig_b) : 1'($urandom_range(1));
      if (v) smp++;
      bus.m_ready = ($urandom_range(99) < rpct);
      if (abort_at >= 0 && m_mode == M_DRAIN && beats == abort_at) begin
        abort = 1; bus.m_ready = 0;
      end
      tick();
      cyc++;
      if (abort) begin
        abort = 0; s_valid = 0; bus.m_ready = 1;
        tick();
        chk("abort_mvalid", bus.m_valid, 0);
        chk("abort_idle", busy, 0);
        idle_inputs();
        return;
      end
      if (m_mode == M_IDLE && beats == DEPTH && done_cnt > 0 && last_beat >= 0 && !busy) begin
        idle_inputs();
        return;
      end
      if (cyc > 20000) begin
        checks++; errors++;
        $display("FAIL timeout act=%0d exp=%0d", cyc, 20000);
        idle_inputs();
        return;
      end
    end
  endtask

  int d0;
  initial begin
    bus.m_ready = 0;
    tick(); tick(); tick();
    chk_zero("reset_state");
    rst_n = 1;
    tick();

    // ramp, trigger at 1500, full-rate drain
    d0 = done_cnt;
    run_capture(1500, -1, 100, 0, 100, -1, -1);
    chk("t1_first", first_beat, 1244);
    chk("t1_last", last_beat, 2267);
    chk("t1_done", done_cnt - d0, 1);
    chk("t1_beats", beats, DEPTH);
    chk("t1_ovf", ovf, 0);

    // early trigger ignored, later one accepted
    run_capture(100, 300, 100, 0, 100, -1, -1);
    chk("t2_first", first_beat, 44);
    chk("t2_last", last_beat, 1067);

    // bursty input, 50% backpressure
    d0 = done_cnt;
    run_capture(700, -1, 70, 0, 50, -1, -1);
    chk("t3_first", first_beat, 444);
    chk("t3_last", last_beat, 1467);
    chk("t3_beats", beats, DEPTH);
    chk("t3_done", done_cnt - d0, 1);

    // input kept alive through drain
    run_capture(600, -1, 100, 100, 100, -1, -1);
    chk("t4_ovf", ovf, 1);
    chk("t4_first", first_beat, 344);
    chk("t4_last", last_beat, 1367);

    // abort after 400 beats, then full re-capture
    d0 = done_cnt;
    run_capture(900, -1, 100, 50, 100, 400, -1);
    chk("t5_no_done", done_cnt - d0, 0);
    chk("t5_beats", beats, 400);
    run_capture(1000, -1, 100, 0, 80, -1, -1);
    chk("t5b_first", first_beat, 744);
    chk("t5b_last", last_beat, 1767);

    // reset pulse in the middle of post-trigger capture, then fresh capture
    run_capture(500, -1, 100, 0, 100, -1, 700);
    run_capture(1200, -1, 100, 0, 100, -1, -1);
    chk("t6_first", first_beat, 944);
    chk("t6_last", last_beat, 1967);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
